// File: rtl/completion_monitor_if.sv
// Bundle of run-control inputs and status outputs exchanged between a test
// sequencer (master) and the completion monitor (slave).
interface completion_monitor_if #(
    parameter int N_CH  = 6,
    parameter int CNT_W = 16
);
    localparam int FF_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             start;
    logic [N_CH-1:0]  ch_done;
    logic [N_CH-1:0]  ch_fail;

    logic             busy;
    logic             completed;
    logic             passed;
    logic             timed_out;
    logic [N_CH-1:0]  done_vec;
    logic [N_CH-1:0]  fail_vec;
    logic [CNT_W-1:0] elapsed;
    logic             fail_valid;
    logic [FF_W-1:0]  first_fail;

    modport master (
        output start, ch_done, ch_fail,
        input  busy, completed, passed, timed_out,
        input  done_vec, fail_vec, elapsed, fail_valid, first_fail
    );

    modport slave (
        input  start, ch_done, ch_fail,
        output busy, completed, passed, timed_out,
        output done_vec, fail_vec, elapsed, fail_valid, first_fail
    );
endinterface

// File: rtl/completion_monitor.sv
// Tracks per-channel done/fail flags across a test run, reporting completion,
// pass/fail, timeout, elapsed cycles and the first failing channel.
module completion_monitor #(
    parameter int              N_CH    = 6,
    parameter int              CNT_W   = 16,
    parameter int              TIMEOUT = 1000,
    parameter logic [N_CH-1:0] CH_MASK = {N_CH{1'b1}}
) (
    input logic                 clk,
    input logic                 rst_n,
    completion_monitor_if.slave bus
);
    localparam int FF_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    generate
        if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
            $error("completion_monitor: N_CH must be in 1..32");
        end
        if (TIMEOUT < 0 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_tmo
            $error("completion_monitor: TIMEOUT must fit in CNT_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        TMO
    } state_t;

    state_t           state;
    logic             busy;
    logic             completed;
    logic             passed;
    logic             timed_out;
    logic [N_CH-1:0]  done_vec;
    logic [N_CH-1:0]  fail_vec;
    logic [CNT_W-1:0] elapsed;
    logic             fail_valid;
    logic [FF_W-1:0]  first_fail;

    logic [N_CH-1:0]  done_nxt;
    logic [N_CH-1:0]  fail_new;
    logic [N_CH-1:0]  fail_nxt;
    logic             all_done;
    logic             tmo_hit;
    logic [CNT_W-1:0] elapsed_inc;
    logic [FF_W-1:0]  new_idx;

    // NOTE: every combinational output gets a default before any conditional
    // update, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        done_nxt    = done_vec | (bus.ch_done & CH_MASK);
        fail_new    = bus.ch_done & bus.ch_fail & CH_MASK;
        fail_nxt    = fail_vec | fail_new;
        // Masked-out channels count as done, so CH_MASK==0 completes at once.
        all_done    = &(done_nxt | ~CH_MASK);
        tmo_hit     = TMO_EN && (elapsed == TMO_LAST);
        elapsed_inc = (&elapsed) ? elapsed : elapsed + CNT_W'(1);
        new_idx     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (fail_new[i]) new_idx = FF_W'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            completed  <= 1'b0;
            passed     <= 1'b0;
            timed_out  <= 1'b0;
            done_vec   <= '0;
            fail_vec   <= '0;
            elapsed    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else if (bus.start) begin
            // Start wins in every state; channel inputs on this edge are dropped.
            state      <= RUN;
            busy       <= 1'b1;
            completed  <= 1'b0;
            passed     <= 1'b0;
            timed_out  <= 1'b0;
            done_vec   <= '0;
            fail_vec   <= '0;
            elapsed    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else if (state == RUN) begin
            done_vec <= done_nxt;
            fail_vec <= fail_nxt;
            elapsed  <= elapsed_inc;
            if (!fail_valid && (fail_new != '0)) begin
                fail_valid <= 1'b1;
                first_fail <= new_idx;
            end
            // Completion outranks a coincident timeout.
            if (all_done) begin
                state     <= DONE;
                busy      <= 1'b0;
                completed <= 1'b1;
                passed    <= (fail_nxt == '0);
            end else if (tmo_hit) begin
                state     <= TMO;
                busy      <= 1'b0;
                timed_out <= 1'b1;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.completed  = completed;
    assign bus.passed     = passed;
    assign bus.timed_out  = timed_out;
    assign bus.done_vec   = done_vec;
    assign bus.fail_vec   = fail_vec;
    assign bus.elapsed    = elapsed;
    assign bus.fail_valid = fail_valid;
    assign bus.first_fail = first_fail;
endmodule

// File: doc/completion_monitor.md
COMPLETION_MONITOR -- requirements
Module: completion_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 6, number of monitored test channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, width of elapsed-cycle counter.
REQ-003 SHALL have parameter TIMEOUT, default 1000, cycles allowed per run; 0 disables timeout; SHALL satisfy TIMEOUT < 2**CNT_W.
REQ-004 SHALL have parameter CH_MASK, default all ones (N_CH bits), channels included in the run; 0 bits are ignored.
REQ-005 SHALL have ports: clk  input  1  clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle request to begin (or restart) a run.
REQ-008 ch_done  input  N_CH  per-channel completion level.
REQ-009 ch_fail  input  N_CH  per-channel failure flag, qualified by ch_done.
REQ-010 busy  output  1  run in progress.
REQ-011 completed  output  1  all unmasked channels done.
REQ-012 passed  output  1  completed with no failures.
REQ-013 timed_out  output  1  run aborted by timeout.
REQ-014 done_vec  output  N_CH  sticky per-channel done.
REQ-015 fail_vec  output  N_CH  sticky per-channel fail.
REQ-016 elapsed  output  CNT_W  cycles since run start.
REQ-017 fail_valid  output  1  at least one failure recorded.
REQ-018 first_fail  output  max(1,clog2(N_CH))  index of first failing channel.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE, TMO; busy=1 only in RUN, completed=1 only in DONE, timed_out=1 only in TMO, passed = DONE and fail_vec==0.
REQ-020 start sampled high in any state SHALL, at that edge, enter RUN, clear done_vec, fail_vec, fail_valid, first_fail, set elapsed=0; ch_done/ch_fail on that edge SHALL be ignored.
REQ-021 In RUN each edge SHALL set done_vec |= ch_done & CH_MASK and fail_vec |= ch_done & ch_fail & CH_MASK; bits never clear except by start/reset.
REQ-022 ch_fail without ch_done SHALL have no effect.
REQ-023 In RUN elapsed SHALL increment by 1 per edge, saturating at all ones (reachable only with TIMEOUT=0); frozen in IDLE, DONE, TMO.
REQ-024 RUN->DONE SHALL occur on the same edge at which (next done_vec | ~CH_MASK) becomes all ones; completed visible the cycle after the last ch_done sample.
REQ-025 RUN->TMO SHALL occur on the edge where TIMEOUT!=0, elapsed==TIMEOUT-1 and completion per REQ-024 is not met; elapsed then reads TIMEOUT.
REQ-026 Completion and timeout on the same edge SHALL resolve to DONE.
REQ-027 CH_MASK==0 SHALL make RUN->DONE occur on the first edge after start, passed=1.
REQ-028 On the first edge a fail bit sets, fail_valid SHALL go 1 and first_fail SHALL take the lowest index among newly failing channels; later failures SHALL not change it.
REQ-029 DONE and TMO SHALL hold all outputs until start or reset; channel inputs ignored.
REQ-030 start in RUN SHALL discard the current run (restart per REQ-020), no intermediate DONE/TMO.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and all outputs 0 (vectors, elapsed, first_fail all zero), independent of clk.
REQ-032 Reset deassertion SHALL take effect on the next rising edge; reset mid-run SHALL abandon the run with no completed/timed_out pulse.

Verification
REQ-033 N_CH=6, TIMEOUT=1000: start, then ch_done bits 0..5 one per cycle, ch_fail=0 -> completed=1, passed=1 cycle after bit 5 sampled, elapsed=6.
REQ-034 Same, ch_fail[3] and ch_fail[1] high with their dones in one cycle, ch_fail[4] later -> passed=0, fail_vec=0b011010, first_fail=1, fail_valid=1.
REQ-035 TIMEOUT=10, only channels 0..4 done -> timed_out=1, elapsed=10, done_vec=0b011111, completed=0; last done on the timeout edge -> DONE instead.
REQ-036 CH_MASK=0b111110, channel 0 never done -> completed after channels 1..5; CH_MASK=0 -> completed one cycle after start.
REQ-037 rst_n pulsed low mid-run between clock edges -> outputs 0 immediately, IDLE; start mid-run -> vectors cleared, elapsed restarts at 0.
